// File: rtl/storage_word_reader_pkg.sv
// Shared definitions for the storage inquiry interface: address widths,
// word size and the reader state encoding.
package storage_word_reader_pkg;

   localparam int WORDINDEXBITS   = 8;
   localparam int LETTERINDEXBITS = 4;
   localparam int LETTERS         = 2 ** LETTERINDEXBITS;

   // Index of the final letter in a word; the counter stops here.
   localparam logic [LETTERINDEXBITS-1:0] LAST_LETTER = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/storage_word_reader_inquiry_timeout_counter.sv
// Loadable down-counter bounding how long the reader waits for readReady
// after an inquiry strobe. Loaded while the strobe is being issued, so the
// strobe cycle is the first waiting cycle and expired rises in the last one.
module storage_word_reader_inquiry_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LOAD_VALUE = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Reload on start, otherwise count down and park at zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= LOAD_VALUE;
      end else if (start) begin
         count <= LOAD_VALUE;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/storage_word_reader.sv
// Read-side initiator for the storage inquiry interface. Accepts a word
// index, issues one inquiry per letter (0..LETTERS-1), gathers each
// storedValue bit and presents the assembled word with a one-cycle pulse.
module storage_word_reader
   import storage_word_reader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       storageReady,
   input  logic                       reqValid,
   output logic                       reqReady,
   input  logic [WORDINDEXBITS-1:0]   reqWordIndex,
   output logic                       inquiry,
   output logic [WORDINDEXBITS-1:0]   inquiryWordIndex,
   output logic [LETTERINDEXBITS-1:0] inquiryLetterIndex,
   input  logic                       readReady,
   input  logic                       storedValue,
   output logic                       wordValid,
   output logic [LETTERS-1:0]         wordData,
   output logic                       wordError
);

   state_t                     state;
   logic [LETTERINDEXBITS-1:0] letter;
   logic                       error_flag;
   logic                       timeout_start;
   logic                       timeout_expired;

   // The wait window opens on the same edge the strobe is registered.
   assign timeout_start = (state == ISSUE) && storageReady;

   storage_word_reader_inquiry_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .start   (timeout_start),
      .expired (timeout_expired)
   );

   // Reader FSM with registered interface outputs. inquiryWordIndex doubles
   // as the latched request index so it cannot move within a word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         reqReady           <= 1'b0;
         inquiry            <= 1'b0;
         inquiryWordIndex   <= '0;
         inquiryLetterIndex <= '0;
         wordValid          <= 1'b0;
         wordData           <= '0;
         wordError          <= 1'b0;
         letter             <= '0;
         error_flag         <= 1'b0;
      end else begin
         inquiry   <= 1'b0;
         wordValid <= 1'b0;
         case (state)
            IDLE: begin
               reqReady <= storageReady;
               if (reqValid && reqReady) begin
                  reqReady         <= 1'b0;
                  inquiryWordIndex <= reqWordIndex;
                  letter           <= '0;
                  error_flag       <= 1'b0;
                  wordData         <= '0;
                  wordError        <= 1'b0;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               reqReady <= 1'b0;
               if (storageReady) begin
                  inquiry            <= 1'b1;
                  inquiryLetterIndex <= letter;
                  state              <= WAIT;
               end
            end
            WAIT: begin
               reqReady <= 1'b0;
               // A response in the final window cycle wins over the timeout.
               if (readReady || timeout_expired) begin
                  wordData[letter] <= readReady & storedValue;
                  if (!readReady) begin
                     error_flag <= 1'b1;
                  end
                  if (letter == LAST_LETTER) begin
                     state <= DONE;
                  end else begin
                     letter <= letter + 1'b1;
                     state  <= ISSUE;
                  end
               end
            end
            DONE: begin
               reqReady  <= 1'b0;
               wordValid <= 1'b1;
               wordError <= error_flag;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_storage_word_reader.sv
// Directed bench for storage_word_reader: a behavioural storage responder
// with per-letter response delay, a vector table of whole-word reads and
// hand-written sequences for the multi-cycle corner cases.
module tb_storage_word_reader;
   import storage_word_reader_pkg::*;

   localparam int T = 16;

   logic                       clock;
   logic                       reset;
   logic                       storageReady;
   logic                       reqValid;
   logic                       reqReady;
   logic [WORDINDEXBITS-1:0]   reqWordIndex;
   logic                       inquiry;
   logic [WORDINDEXBITS-1:0]   inquiryWordIndex;
   logic [LETTERINDEXBITS-1:0] inquiryLetterIndex;
   logic                       readReady;
   logic                       storedValue;
   logic                       wordValid;
   logic [LETTERS-1:0]         wordData;
   logic                       wordError;

   storage_word_reader #(.TIMEOUT_CYCLES(T)) dut (
      .clock              (clock),
      .reset              (reset),
      .storageReady       (storageReady),
      .reqValid           (reqValid),
      .reqReady           (reqReady),
      .reqWordIndex       (reqWordIndex),
      .inquiry            (inquiry),
      .inquiryWordIndex   (inquiryWordIndex),
      .inquiryLetterIndex (inquiryLetterIndex),
      .readReady          (readReady),
      .storedValue        (storedValue),
      .wordValid          (wordValid),
      .wordData           (wordData),
      .wordError          (wordError)
   );

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // Responder configuration and expectations shared with the monitor.
   int                         sp_letter = -1;
   int                         sp_delay  = 1;
   logic [WORDINDEXBITS-1:0]   exp_word  = '0;
   logic [LETTERINDEXBITS-1:0] exp_letter = '0;
   int                         inq_count = 0;
   int                         last_valid_cyc = 0;

   typedef struct {
      logic [7:0]  word;
      int          sp_letter;
      int          sp_delay;
      logic [15:0] exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[5];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cycle index advances on every active edge.
   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [7:0] w);
      case (w)
         8'h05:   return 16'hA5C3;
         8'h00:   return 16'h1234;
         8'hFF:   return 16'hBEEF;
         8'h3C:   return 16'h8001;
         default: return {w, ~w};
      endcase
   endfunction

   // Storage model: response delay 1 lands in the strobe cycle itself,
   // delay k in the k-th cycle after the strobe is seen, 0 drops it.
   bit                         pend = 0;
   int                         wcnt = 0;
   logic [LETTERINDEXBITS-1:0] cur_letter = '0;
   logic [WORDINDEXBITS-1:0]   cur_word = '0;
   always @(negedge clock) begin
      int          d;
      logic [15:0] mw;
      if (reset) begin
         pend        = 0;
         readReady   = 1'b0;
         storedValue = 1'b0;
      end else begin
         if (inquiry) begin
            inq_count++;
            check("inq_word", 32'(inquiryWordIndex), 32'(exp_word));
            check("inq_letter", 32'(inquiryLetterIndex), 32'(exp_letter));
            exp_letter = exp_letter + 1'b1;
            pend       = 1;
            wcnt       = 1;
            cur_letter = inquiryLetterIndex;
            cur_word   = inquiryWordIndex;
         end else if (pend) begin
            wcnt++;
         end
         readReady   = 1'b0;
         storedValue = 1'b0;
         if (pend) begin
            d = (int'(cur_letter) == sp_letter) ? sp_delay : 1;
            if (wcnt == d) begin
               mw          = mem_word(cur_word);
               readReady   = 1'b1;
               storedValue = mw[cur_letter];
               pend        = 0;
            end else if (wcnt > 40) begin
               pend = 0;
            end
         end
      end
   end

   task automatic start_req(input logic [7:0] w, output int c0);
      bit got;
      got = 0;
      c0  = 0;
      reqValid     = 1'b1;
      reqWordIndex = w;
      for (int i = 0; i < 100 && !got; i++) begin
         if (reqReady) begin
            got        = 1;
            c0         = cyc;
            exp_word   = w;
            exp_letter = '0;
            inq_count  = 0;
         end else begin
            @(negedge clock);
         end
      end
      check("req_accept", 32'(got), 32'd1);
      @(negedge clock);
      reqValid = 1'b0;
   endtask

   task automatic finish_req(input string tag, input logic [15:0] ed, input logic ee,
                             input int lat, input int c0);
      bit got;
      int early;
      int c1;
      got = 0; early = 0; c1 = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clock);
         if (wordValid) begin
            got = 1;
            c1  = cyc;
            check({tag, "_data"}, 32'(wordData), 32'(ed));
            check({tag, "_err"}, 32'(wordError), 32'(ee));
         end else if (reqReady) begin
            early++;
         end
      end
      check({tag, "_valid_seen"}, 32'(got), 32'd1);
      if (got) begin
         last_valid_cyc = c1;
         check({tag, "_latency"}, 32'(c1 - c0), 32'(lat));
         check({tag, "_inquiries"}, 32'(inq_count), 32'd16);
         check({tag, "_busy_ready"}, 32'(early), 32'd0);
         @(negedge clock);
         check({tag, "_valid_once"}, 32'(wordValid), 32'd0);
      end
      $display("read %s: word=%0h data=%0h err=%0b cycles=%0d", tag, exp_word, wordData, wordError, c1 - c0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_reqReady"}, 32'(reqReady), 32'd0);
      check({tag, "_inquiry"}, 32'(inquiry), 32'd0);
      check({tag, "_inqWord"}, 32'(inquiryWordIndex), 32'd0);
      check({tag, "_inqLetter"}, 32'(inquiryLetterIndex), 32'd0);
      check({tag, "_wordValid"}, 32'(wordValid), 32'd0);
      check({tag, "_wordData"}, 32'(wordData), 32'd0);
      check({tag, "_wordError"}, 32'(wordError), 32'd0);
   endtask

   // Main stimulus: reset, vector table, then the multi-cycle sequences.
   initial begin
      int c0;
      int c0b;
      int n;
      bit found;

      vecs[0] = '{8'h05, -1, 1,  16'hA5C3, 1'b0, 34};
      vecs[1] = '{8'h05,  7, 0,  16'hA543, 1'b1, 49};
      vecs[2] = '{8'h05, 15, T,  16'hA5C3, 1'b0, 49};
      vecs[3] = '{8'h3C,  0, 0,  16'h8000, 1'b1, 49};
      vecs[4] = '{8'h05,  0, T + 1, 16'hA5C2, 1'b1, 49};

      reset        = 1'b1;
      storageReady = 1'b1;
      reqValid     = 1'b0;
      reqWordIndex = '0;
      repeat (3) @(negedge clock);
      check_reset_outputs("por");
      reset = 1'b0;
      @(negedge clock);

      for (int v = 0; v < 5; v++) begin
         sp_letter = vecs[v].sp_letter;
         sp_delay  = vecs[v].sp_delay;
         start_req(vecs[v].word, c0);
         finish_req($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat, c0);
      end
      sp_letter = -1;
      sp_delay  = 1;

      // storageReady low at request time: no acceptance, no inquiry.
      storageReady = 1'b0;
      @(negedge clock);
      reqValid     = 1'b1;
      reqWordIndex = 8'h05;
      n = inq_count;
      repeat (3) begin
         @(negedge clock);
         check("sr_low_reqReady", 32'(reqReady), 32'd0);
      end
      check("sr_low_no_inquiry", 32'(inq_count), 32'(n));
      storageReady = 1'b1;
      @(negedge clock);
      check("sr_rise_reqReady", 32'(reqReady), 32'd1);
      start_req(8'h05, c0);
      finish_req("sr", 16'hA5C3, 1'b0, 34, c0);

      // Reset while letter 9 is in flight, then a clean read from letter 0.
      start_req(8'h05, c0);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clock);
         if (inquiry && inquiryLetterIndex == 4'd9) found = 1;
      end
      check("rst_reach_letter9", 32'(found), 32'd1);
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      repeat (2) begin
         @(negedge clock);
         check("midrst_no_valid", 32'(wordValid), 32'd0);
      end
      reset = 1'b0;
      @(negedge clock);
      start_req(8'h00, c0);
      finish_req("after_rst", 16'h1234, 1'b0, 34, c0);

      // Back-to-back: second request held on reqValid during the first word.
      start_req(8'h00, c0);
      reqValid     = 1'b1;
      reqWordIndex = 8'hFF;
      finish_req("b2b_first", 16'h1234, 1'b0, 34, c0);
      start_req(8'hFF, c0b);
      check("b2b_accept_gap", 32'(c0b - last_valid_cyc), 32'd1);
      finish_req("b2b_second", 16'hBEEF, 1'b0, 34, c0b);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
